// File: rtl/mac_accum8_pkg.sv
// mac_accum8_pkg: shared state encoding and product width for the accumulator
package mac_accum8_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  localparam int PROD_W = 8;
endpackage

// File: rtl/mac_accum8_sat.sv
// sat_add: unsigned add of a product into a W-bit value, clamping to all-ones on carry-out
import mac_accum8_pkg::*;
module sat_add #(
  parameter int W = 10
) (
  input  logic [W-1:0]      a,
  input  logic [PROD_W-1:0] b,
  output logic [W-1:0]      sum,
  output logic              sat
);
  logic [W:0] full;
  assign full = {1'b0, a} + (W+1)'(b);
  assign sat  = full[W];
  assign sum  = sat ? '1 : full[W-1:0];
endmodule

// File: rtl/mac_accum8.sv
// mac_accum8: accumulate N_TERMS products per batch into a saturated sum with sticky overflow
import mac_accum8_pkg::*;
module mac_accum8 #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [PROD_W-1:0] prod,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf,
  output logic              out_valid,
  input  logic              out_ready
);
  localparam int CW = $clog2(N_TERMS + 1);
  state_t state, state_nx;
  logic [ACC_W-1:0] acc, acc_nx, sum;
  logic [CW-1:0] cnt, cnt_nx;
  logic ovf, ovf_nx, sat;
  sat_add #(.W(ACC_W)) u_add (.a(acc), .b(prod), .sum(sum), .sat(sat));
  // rst_n gates in_ready so nothing looks acceptable while reset is held
  assign in_ready  = rst_n && state != DONE;
  assign out_valid = state == DONE;
  assign out_sum   = acc;
  assign out_ovf   = ovf;
  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    ovf_nx   = ovf;
    if (clear) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      ovf_nx   = 1'b0;
    end else if (state == DONE) begin
      if (out_ready) begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    end else if (in_valid && in_ready) begin
      acc_nx   = state == IDLE ? ACC_W'(prod) : sum;
      ovf_nx   = state == IDLE ? 1'b0 : ovf | sat;
      cnt_nx   = state == IDLE ? CW'(1) : cnt + CW'(1);
      state_nx = (cnt_nx == CW'(N_TERMS)) ? DONE : ACCUM;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
      ovf   <= ovf_nx;
    end
  end
endmodule
